// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and helpers for the AES-128 key-expansion support logic.
//   - byte_t / word_t / round_idx_t : common datapath types
//   - SBOX  : 256-entry forward AES S-box (GF(2^8) inverse + affine 0x63)
//   - RCON  : 16-entry round-constant table, entries 10..15 are zero so the
//             4-bit round counter can wrap freely without saturation logic
//   - sbox_lookup / rcon_word : small helpers around the two tables
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  round_idx_t;

    // Value presented on rcon straight after reset or a key load.
    localparam word_t RCON_START = 32'h0100_0000;

    // Forward S-box, index = input byte.
    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constants x^i in GF(2^8) for i = 0..9; the trailing zeros make
    // the sequence read 00 for six rounds before the counter wraps to 01.
    localparam byte_t RCON [16] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic byte_t sbox_lookup(input byte_t b);
        return SBOX[b];
    endfunction

    // Round constant placed in the top byte of a key word.
    function automatic word_t rcon_word(input round_idx_t idx);
        return {RCON[idx], 24'h00_0000};
    endfunction

endpackage

// File: rtl/aes_ks_primitives_if.sv
// -----------------------------------------------------------------------------
// aes_ks_primitives_if
// Bundle between the key expander (master) and aes_ks_primitives (slave).
//   kld    : key-load strobe, restarts the round-constant sequence
//   sb_in  : word to be substituted (already rotated by the caller)
//   rcon   : current round constant, constant byte in [31:24]
//   sb_out : SubWord(sb_in)
// -----------------------------------------------------------------------------
interface aes_ks_primitives_if;
    import aes_pkg::*;

    logic  kld;
    word_t sb_in;
    word_t rcon;
    word_t sb_out;

    modport master (
        output kld,
        output sb_in,
        input  rcon,
        input  sb_out
    );

    modport slave (
        input  kld,
        input  sb_in,
        output rcon,
        output sb_out
    );

endinterface

// File: rtl/aes_sbox_byte.sv
// -----------------------------------------------------------------------------
// aes_sbox_byte
// One lane of the forward AES S-box, purely combinational.
//   in_byte  : byte to substitute
//   out_byte : S(in_byte)
// -----------------------------------------------------------------------------
module aes_sbox_byte
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    assign out_byte = sbox_lookup(in_byte);

endmodule

// File: rtl/aes_ks_primitives.sv
// -----------------------------------------------------------------------------
// aes_ks_primitives
// Support block for the AES-128 key expander:
//   - a registered round-constant sequencer, restarted by kld and stepping
//     one round per clock, wrapping through six zero rounds back to 01
//   - four combinational S-box lanes forming SubWord on a 32-bit word
// Ports:
//   clk : rising-edge clock for the sequencer
//   rst : synchronous active-high reset
//   bus : aes_ks_primitives_if.slave (kld, sb_in in; rcon, sb_out out)
// -----------------------------------------------------------------------------
module aes_ks_primitives
    import aes_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    aes_ks_primitives_if.slave         bus
);

    round_idx_t rcnt;
    round_idx_t next_idx;
    word_t      rcon_q;
    word_t      sb_word;

    // Natural 4-bit wrap gives the mod-16 table walk; RCON holds zeros for
    // the unused rounds so no saturation is needed.
    assign next_idx = rcnt + 4'd1;

    // Round-constant sequencer: reset and key load both restart at round 0,
    // otherwise advance one round and register the matching constant.
    always_ff @(posedge clk) begin
        if (rst || bus.kld) begin
            rcnt   <= '0;
            rcon_q <= RCON_START;
        end else begin
            rcnt   <= next_idx;
            rcon_q <= rcon_word(next_idx);
        end
    end

    assign bus.rcon = rcon_q;

    // SubWord: one independent S-box per byte lane, no byte rotation here.
    for (genvar n = 0; n < 4; n++) begin : g_lane
        aes_sbox_byte u_sbox (
            .in_byte  (bus.sb_in[8*n +: 8]),
            .out_byte (sb_word[8*n +: 8])
        );
    end

    assign bus.sb_out = sb_word;

endmodule

// File: tb/tb_aes_ks_primitives.sv
// -----------------------------------------------------------------------------
// tb_aes_ks_primitives
// Scoreboard bench for aes_ks_primitives. The stimulus process drives inputs
// on the falling edge and queues the expected rcon/sb_out; the monitor pops
// and compares shortly after each rising edge. Expected values come from a
// reference model built from GF(2^8) arithmetic, plus a few literal vectors.
// -----------------------------------------------------------------------------
module tb_aes_ks_primitives;

    typedef struct {
        logic [31:0] rcon_exp;
        logic [31:0] sb_exp;
        string       name;
    } exp_item_t;

    logic clk;
    logic rst;

    aes_ks_primitives_if bus ();

    aes_ks_primitives dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_item_t   sb_q[$];
    logic [7:0]  ref_sbox [256];
    int          model_round;
    int          assert_count;
    int          fail_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gf_mul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        logic [7:0] c;
        logic [7:0] y;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
        return y;
    endfunction

    // Round constant i is x^i for i < 10, zero for the remaining slots.
    function automatic logic [7:0] rc_ref(input int idx);
        logic [7:0] v;
        if (idx >= 10) return 8'h00;
        v = 8'h01;
        for (int i = 0; i < idx; i++) v = gf_mul(v, 8'h02);
        return v;
    endfunction

    function automatic logic [31:0] subword_ref(input logic [31:0] s);
        return {ref_sbox[s[31:24]], ref_sbox[s[23:16]], ref_sbox[s[15:8]], ref_sbox[s[7:0]]};
    endfunction

    task automatic applyStimulus(input logic r, input logic k, input logic [31:0] s,
                                 input logic use_lit, input logic [31:0] lit_sb,
                                 input string name);
        exp_item_t item;
        @(negedge clk);
        rst       = r;
        bus.kld   = k;
        bus.sb_in = s;
        if (r || k) model_round = 0;
        else        model_round = model_round + 1;
        item.rcon_exp = {rc_ref(model_round % 16), 24'h0};
        item.sb_exp   = use_lit ? lit_sb : subword_ref(s);
        item.name     = name;
        sb_q.push_back(item);
    endtask

    task automatic checkOutput(input exp_item_t item);
        assert_count++;
        if (bus.rcon !== item.rcon_exp) begin
            fail_count++;
            $display("[TB] FAIL %s rcon: got %h expected %h", item.name, bus.rcon, item.rcon_exp);
        end
        assert_count++;
        if (bus.sb_out !== item.sb_exp) begin
            fail_count++;
            $display("[TB] FAIL %s sb_out: got %h expected %h (sb_in %h)",
                     item.name, bus.sb_out, item.sb_exp, bus.sb_in);
        end
    endtask

    // Monitor: compares after every rising edge for which an expectation exists.
    initial begin
        exp_item_t item;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                item = sb_q.pop_front();
                checkOutput(item);
            end
        end
    end

    // Stimulus.
    initial begin
        logic [7:0] v;
        logic [31:0] s;
        assert_count = 0;
        fail_count   = 0;
        model_round  = 0;
        rst          = 1'b1;
        bus.kld      = 1'b0;
        bus.sb_in    = 32'h0;

        for (int i = 0; i < 256; i++) ref_sbox[i] = affine(gf_inv(i[7:0]));
        $display("[TB] reference model ready");

        // Reset state, with literal word-lane vectors.
        applyStimulus(1'b1, 1'b0, 32'h00000000, 1'b1, 32'h63636363, "reset_zero_word");
        applyStimulus(1'b0, 1'b1, 32'hcf4f3c09, 1'b1, 32'h8a84eb01, "kld_word_cf4f3c09");
        applyStimulus(1'b0, 1'b0, 32'h00015300, 1'b1, 32'h637ced63, "spot_00_01_53");
        applyStimulus(1'b0, 1'b0, 32'hc9ff0001, 1'b1, 32'hdd16637c, "spot_c9_ff");

        // Full load sequence: pulse then 16 advances including the wrap.
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, "load_pulse");
        for (int i = 0; i < 16; i++) begin
            s = $urandom;
            applyStimulus(1'b0, 1'b0, s, 1'b0, 32'h0, "load_seq");
        end

        // Restart mid-sequence once rcon reaches 10.
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, "restart_pulse");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 32'h0, "to_10");
        applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 32'h0, "restart_mid");
        applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 32'h0, "restart_next");

        // Reset while rcon = 80, then rst and kld together, then release.
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, "pre_rst_pulse");
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 32'h0, "to_80");
        applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 32'h0, "rst_at_80");
        applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 32'h0, "after_rst");
        applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 32'h0, "rst_and_kld");
        applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 32'h0, "release_both");

        // kld held high for five cycles, then released.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 32'h0, "kld_held");
        applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 32'h0, "kld_release");

        // Exhaustive S-box: every lane sees every byte value once.
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            s = {v + 8'd192, v + 8'd128, v + 8'd64, v};
            applyStimulus(1'b0, 1'b0, s, 1'b0, 32'h0, "exhaustive");
        end

        // Random mix of resets, loads and words.
        for (int i = 0; i < 200; i++) begin
            applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                          $urandom, 1'b0, 32'h0, "random");
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
